// File: rtl/mem_xfer_pkg.sv
// Shared types and constants for the memory-transfer buffer.
package mem_xfer_pkg;

    typedef enum logic {
        PH_FILL  = 1'b0,
        PH_DRAIN = 1'b1
    } phase_t;

    localparam int MODE_FIFO  = 0;
    localparam int MODE_BLOCK = 1;

    // Occupancy needs one bit more than the address so that DEPTH itself is representable.
    function automatic int count_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/mem_xfer_ram.sv
// Simple dual-port storage: one write port, one registered read port.
module mem_xfer_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             Reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is deliberately never reset; only the read register is.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!Reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/mem_xfer_buffer.sv
// Transfer buffer with address counters, occupancy, flags and error pulses; FIFO or fill-then-drain mode.
module mem_xfer_buffer
    import mem_xfer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int MODE  = 0,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             Reset,
    input  logic             Clear,
    input  logic             WE,
    input  logic [WIDTH-1:0] DataIn,
    input  logic             RE,
    output logic [WIDTH-1:0] DataOut,
    output logic             RValid,
    output logic [AW-1:0]    AddrW,
    output logic [AW-1:0]    AddrR,
    output logic [AW:0]      Count,
    output logic             Full,
    output logic             Empty,
    output logic             Phase,
    output logic             WrErr,
    output logic             RdErr
);

    localparam int CW = count_w(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(DEPTH - 1);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);

    phase_t state;
    phase_t state_next;
    logic   fill_en;
    logic   drain_en;
    logic   run;
    logic   wr_ok;
    logic   rd_ok;

    assign Full  = (Count == FULL_CNT);
    assign Empty = (Count == '0);

    // Reset and Clear both suppress any access in their cycle, so no error pulses either.
    assign run   = Reset & ~Clear;
    assign wr_ok = run & WE & ~Full  & fill_en;
    assign rd_ok = run & RE & ~Empty & drain_en;

    always_ff @(posedge clock) begin
        if (!Reset || Clear) begin
            state <= PH_FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (MODE == MODE_BLOCK) begin
            case (state)
                PH_FILL:  if (wr_ok && Count == LAST_CNT) state_next = PH_DRAIN;
                PH_DRAIN: if (rd_ok && Count == ONE_CNT)  state_next = PH_FILL;
                default:  state_next = PH_FILL;
            endcase
        end
    end

    // In FIFO mode both sides are always enabled and the phase reads as FILL.
    always_comb begin
        fill_en  = 1'b1;
        drain_en = 1'b1;
        Phase    = 1'b0;
        if (MODE == MODE_BLOCK) begin
            fill_en  = (state == PH_FILL);
            drain_en = (state == PH_DRAIN);
            Phase    = (state == PH_DRAIN);
        end
    end

    always_ff @(posedge clock) begin
        if (!Reset || Clear) begin
            AddrW  <= '0;
            AddrR  <= '0;
            Count  <= '0;
            RValid <= 1'b0;
            WrErr  <= 1'b0;
            RdErr  <= 1'b0;
        end else begin
            if (wr_ok) begin
                AddrW <= AddrW + 1'b1;
            end
            if (rd_ok) begin
                AddrR <= AddrR + 1'b1;
            end
            Count  <= Count + {{AW{1'b0}}, wr_ok} - {{AW{1'b0}}, rd_ok};
            RValid <= rd_ok;
            WrErr  <= WE & ~wr_ok;
            RdErr  <= RE & ~rd_ok;
        end
    end

    // DataOut lives in the RAM read register: reset clears it, Clear leaves it alone.
    mem_xfer_ram #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_ram (
        .clock  (clock),
        .Reset  (Reset),
        .wr_en  (wr_ok),
        .wr_addr(AddrW),
        .wr_data(DataIn),
        .rd_en  (rd_ok),
        .rd_addr(AddrR),
        .rd_data(DataOut)
    );

endmodule

// File: doc/mem_xfer_buffer.md
# mem_xfer_buffer

Parametrised transfer buffer for the memory-transfer datapath: a WIDTH×DEPTH storage array with auto-incrementing write and read address counters, occupancy tracking, full/empty flags and rejected-access error pulses. It generalises the fixed 8-bit × 4-entry write-counter memory with:

- a read side
- arbitrary width and power-of-two depth
- two operating modes: a streaming FIFO mode, and a block-transfer mode that fills completely before draining.

It sits between a source memory/counter stage and the destination stage.

## Interface
Parameters:
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 4, number of entries; power of two, ≥2
- MODE, 0, 0 = FIFO (concurrent write/read), 1 = BLOCK (fill-then-drain)
- AW (localparam), $clog2(DEPTH), address width

Ports (reset Reset, synchronous, active-low; clock clock):
- clock  input  1  rising-edge clock
- Reset  input  1  synchronous active-low reset
- Clear  input  1  synchronous flush; pointers, count and state only
- WE  input  1  write request
- DataIn  input  WIDTH  write data
- RE  input  1  read request
- DataOut  output  WIDTH  registered read data
- RValid  output  1  DataOut valid; one-cycle pulse per accepted read
- AddrW  output  AW  next write address
- AddrR  output  AW  next read address
- Count  output  AW+1  occupancy, 0..DEPTH
- Full  output  1  Count == DEPTH
- Empty  output  1  Count == 0
- Phase  output  1  BLOCK state: 0 = FILL, 1 = DRAIN; constant 0 in FIFO mode
- WrErr  output  1  one-cycle pulse: WE asserted but write rejected
- RdErr  output  1  one-cycle pulse: RE asserted but read rejected

## Operation
- **Write acceptance**
  - FIFO mode: wr_ok = WE & !Full.
  - BLOCK mode: wr_ok = WE & !Full & Phase==FILL.
  - On wr_ok: mem[AddrW] ← DataIn; AddrW ← AddrW+1 mod DEPTH (natural AW-bit wrap).
- **Read acceptance**
  - FIFO mode: rd_ok = RE & !Empty.
  - BLOCK mode: rd_ok = RE & !Empty & Phase==DRAIN.
  - On rd_ok: DataOut ← mem[AddrR]; RValid ← 1; AddrR ← AddrR+1 mod DEPTH.
  - Otherwise RValid ← 0 and DataOut holds its value.
- **Flags and counter**
  - Full, Empty and acceptance are evaluated from the pre-edge Count.
  - Count ← Count + wr_ok − rd_ok. No overflow or underflow is possible.
- **Simultaneous WE and RE (FIFO mode)**
  - Both accepted when 0 < Count < DEPTH; Count unchanged.
  - When Full: the read is accepted, the write is rejected (WrErr), Count becomes DEPTH−1.
  - When Empty: the write is accepted, the read is rejected (RdErr). There is no fall-through; the word becomes readable on the next cycle.
- **BLOCK state machine**, states FILL(0) and DRAIN(1):
  - FILL→DRAIN on the accepted write that makes Count == DEPTH.
  - DRAIN→FILL on the accepted read that makes Count == 0.
  - Requests from the wrong phase are rejected and pulse the matching error output.
- **Errors**
  - WrErr = WE & !wr_ok; RdErr = RE & !rd_ok. Both are registered one-cycle pulses.
  - No other state changes on a rejected access.
- **Reset and Clear**
  - Priority: Reset over Clear over normal operation.
  - Reset (Reset==0 at the edge): AddrW=0, AddrR=0, Count=0, Phase=FILL, RValid=0, WrErr=0, RdErr=0, DataOut=0.
  - Clear: same as Reset except DataOut holds.
  - Memory contents are never reset or cleared.
  - Reset or Clear mid-transfer discards all buffered words immediately. A concurrent WE/RE in that cycle is ignored and produces no error pulse.

## Timing
- All outputs are registered; there is no combinational input→output path.
- Write-to-read latency: a word written at edge N can be accepted for reading at edge N+1 and appears on DataOut/RValid after that edge.
- Read latency: 1 cycle from the RE edge to DataOut valid.
- Error pulses appear after the edge that sampled the rejected request.
- Sustained throughput:
  - FIFO mode: 1 write + 1 read per cycle.
  - BLOCK mode: one full transfer takes DEPTH write cycles followed by DEPTH read cycles.

## Structure
- Package mem_xfer_pkg holds:
  - the phase enum (PH_FILL, PH_DRAIN)
  - the mode constants (MODE_FIFO, MODE_BLOCK)
  - a function for the count width
- Sub-module mem_xfer_ram: simple dual-port array, 1 write port and 1 registered read port, parametrised WIDTH/DEPTH, with no reset on storage.
- The top level holds the pointers, counter, phase FSM and error logic.

## Test plan
- **Reset values:** Reset=0 for 2 cycles with WE=RE=1 → all outputs 0, Empty=1, Phase=0, no error pulses.
- **FIFO fill and drain (WIDTH=8, DEPTH=4):** write 0xA1..0xA4 → Full=1, Count=4. A fifth WE → WrErr pulse, Count stays 4. Read 4 words → DataOut sequence A1, A2, A3, A4, each 1 cycle after RE. A further RE → RdErr, Empty=1.
- **Wrap and simultaneous access (FIFO):** 10 cycles of simultaneous WE/RE at Count=2 → AddrW/AddrR wrap 3→0, Count stays 2, data returned in order.
  - Full with both requests → read only accepted, Count=3.
  - Empty with both requests → write only accepted, Count=1, RdErr pulse.
- **BLOCK mode (DEPTH=4):** RE during FILL → RdErr. The 4th write → Phase=1. WE during DRAIN → WrErr. The 4th read → Phase=0, Empty=1.
- **Clear mid-operation:** with Count=3 and last DataOut=0x55, Clear=1 with WE=1 → Count=0, AddrW=AddrR=0, Phase=0, DataOut still 0x55, no WrErr. Reset asserted together with Clear → DataOut=0.
